ser2par_capture: RTL
====================

Name: ser2par_capture

Overview:
- Upstream feeder for the "11"-run sequence detector.
- Collects a serial bit stream, MSB first, into WIDTH-bit parallel words and presents each completed word on a valid/ready interface. The detector consumes this as its din.
- A one-entry holding register decouples serial capture from the downstream consumer.
- An inter-bit timeout discards stale partial words.

Parameters:
- WIDTH, 8: bits per word (legal 2..16).
- TIMEOUT, 16: consecutive idle cycles in SHIFT before a partial word is discarded (legal 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data bit.
- bit_vld  in  1  bit_in is valid this cycle.
- bit_rdy  out  1  block can accept a bit this cycle.
- word_out  out  WIDTH  completed word; first received bit is at word_out[WIDTH-1].
- word_vld  out  1  word_out holds an unconsumed word.
- word_rdy  in  1  downstream accepts word_out.
- frame_err  out  1  one-cycle pulse when a partial word is discarded.
- bit_cnt  out  $clog2(WIDTH+1)  bits currently held in the shift register.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - On reset: state=IDLE, shift register=0, bit_cnt=0, word_out=0, word_vld=0, frame_err=0, idle timer=0.
  - Reset asserted mid-word or mid-handshake discards everything with no frame_err.
- Bit acceptance:
  - A bit is accepted when bit_vld & bit_rdy at a rising edge.
  - Shift rule: sr <= {sr[WIDTH-2:0], bit_in}.
  - bit_rdy = ~(word_vld & (bit_cnt == WIDTH-1)). It is purely registered-state based, with no combinational path from word_rdy.
- FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on an accepted bit; bit_cnt becomes 1.
  - In SHIFT, each accepted bit increments bit_cnt.
  - SHIFT -> IDLE on the WIDTH-th accepted bit. Word completion then happens:
    - word_out <= {sr[WIDTH-2:0], bit_in}, word_vld <= 1, bit_cnt <= 0.
    - Latency is 1 cycle from the last bit to word_vld high.
  - SHIFT -> IDLE on timeout:
    - The idle timer increments each SHIFT cycle with no accepted bit while bit_rdy=1. It is frozen while bit_rdy=0, so backpressure never times out.
    - The timer clears on every accepted bit and on entry to IDLE.
    - When the timer reaches TIMEOUT-1 and another idle cycle occurs: sr and bit_cnt are cleared, frame_err pulses for 1 cycle, and state returns to IDLE.
- Output handshake:
  - word_vld drops the cycle after word_vld & word_rdy, unless a new word completes on that same edge. In that case word_out reloads and word_vld stays 1.
  - word_out is stable while word_vld=1 & word_rdy=0.
- Boundary cases:
  - Holding register full with WIDTH-1 bits shifted: bit_rdy=0 and the stream stalls. A word is never lost or overwritten.
  - Holding register full with fewer than WIDTH-1 bits shifted: capture continues.
  - word_rdy while word_vld=0 is ignored.
  - bit_vld while bit_rdy=0: the bit is not taken and must be held by the source.

Optional Feature:
- Macro: SER2PAR_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by 1 even-parity bit (parity over the data bits).
  - The counter runs to WIDTH+1.
  - bit_rdy stall condition becomes bit_cnt == WIDTH.
  - Parity mismatch: the word is dropped (word_vld unchanged) and frame_err pulses for 1 cycle.
  - Parity match: the word loads as normal, 1 cycle after the parity bit.
- Undefined: no parity bit; frame_err is driven only by timeout.

Decomposition:
- Package ser2par_pkg holds:
  - State enum (IDLE=1'b0, SHIFT=1'b1).
  - Default WIDTH and TIMEOUT localparams.
  - A function computing bit_cnt width.
- Sub-module ser2par_idle_timer: a saturating timer with clear, enable, and expire outputs, instantiated once.

Test Plan:
- Shift in 1,1,0,1,1,1,0,0 with word_rdy=1 -> word_out=8'hDC, word_vld high exactly 1 cycle, 1 cycle after the 8th bit.
- Send word 8'hFF with word_rdy=0, then 7 bits of 8'h0F -> bit_rdy=0 with bit_cnt=7. Raise word_rdy -> 8'hFF consumed. Then send the 8th bit -> 8'h0F presented, with no loss.
- Send 3 bits, then no bit_vld for 16 cycles -> frame_err pulses once, bit_cnt=0, word_vld stays 0. The next 8 bits 8'hA5 yield word_out=8'hA5.
- Assert rst_n low after 5 bits and while word_vld=1 -> all outputs 0 immediately (asynchronous), no frame_err. A following 8'h3C is captured cleanly.
- Back-to-back continuous bit_vld with word_rdy=1 for words 8'h01, 8'h80 -> two word_vld pulses exactly 8 cycles apart, no stall.
- With SER2PAR_PARITY_EN: 8'h03 + parity 0 -> word accepted. 8'h03 + parity 1 -> frame_err pulse, no word_vld.

Source files
------------

// File: rtl/ser2par_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ser2par_pkg
//  Brief    : Shared types, defaults and sizing helper for ser2par_capture.
//  Revision : 1.0 - initial release
// ============================================================================
package ser2par_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int c_DEFAULT_WIDTH   = 8;
    localparam int c_DEFAULT_TIMEOUT = 16;

    // With parity the counter must also represent WIDTH+1 bits in flight.
    function automatic int cnt_width(input int width);
`ifdef SER2PAR_PARITY_EN
        return $clog2(width + 2);
`else
        return $clog2(width + 1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser2par_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : ser2par_capture_if
//  Brief    : Serial-bit input and parallel-word output bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface ser2par_capture_if
    import ser2par_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             bit_in;
    logic             bit_vld;
    logic             bit_rdy;
    logic [WIDTH-1:0] word_out;
    logic             word_vld;
    logic             word_rdy;
    logic             frame_err;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output bit_in, bit_vld, word_rdy,
        input  bit_rdy, word_out, word_vld, frame_err, bit_cnt
    );

    modport slave (
        input  bit_in, bit_vld, word_rdy,
        output bit_rdy, word_out, word_vld, frame_err, bit_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ser2par_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ser2par_idle_timer
//  Brief    : Saturating idle counter; o_expire flags the idle cycle after
//             TIMEOUT-1 idle cycles have already been counted.
//  Revision : 1.0 - initial release
// ============================================================================
module ser2par_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expire
);
    localparam int              c_CW   = $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en & (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ser2par_capture.sv
`default_nettype none
// ============================================================================
//  Module   : ser2par_capture
//  Brief    : MSB-first serial-to-parallel capture with one-word holding
//             register and inter-bit timeout. Define SER2PAR_PARITY_EN to
//             append and check an even-parity bit per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module ser2par_capture
    import ser2par_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ser2par_capture_if.slave  bus
);
    localparam int c_CNT_W = cnt_width(WIDTH);
`ifdef SER2PAR_PARITY_EN
    localparam int c_FRAME = WIDTH + 1;
    localparam int c_SR_W  = WIDTH;
`else
    localparam int c_FRAME = WIDTH;
    // The final data bit goes straight to the holding register.
    localparam int c_SR_W  = WIDTH - 1;
`endif
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_FRAME - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SR_W-1:0]  r_sr;
    logic [c_SR_W-1:0]  w_sr_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_word;
    logic [WIDTH-1:0]   w_word_nxt;
    logic               r_word_vld;
    logic               r_frame_err;
    logic               w_bit_rdy;
    logic               w_acc;
    logic               w_last;
    logic               w_load;
    logic               w_perr;
    logic               w_shift_en;
    logic               w_tmr_en;
    logic               w_tmr_clr;
    logic               w_timeout;

    assign w_bit_rdy  = ~(r_word_vld & (r_cnt == c_LAST));
    assign w_acc      = bus.bit_vld & w_bit_rdy;
    assign w_last     = w_acc & (r_cnt == c_LAST);
    assign w_sr_shift = c_SR_W'({r_sr, bus.bit_in});

`ifdef SER2PAR_PARITY_EN
    assign w_word_nxt = r_sr;
    assign w_perr     = w_last & ((^r_sr) != bus.bit_in);
    assign w_load     = w_last & ~w_perr;
    assign w_shift_en = w_acc & (r_cnt < c_CNT_W'(WIDTH));
`else
    assign w_word_nxt = {r_sr, bus.bit_in};
    assign w_perr     = 1'b0;
    assign w_load     = w_last;
    assign w_shift_en = w_acc;
`endif

    // Backpressure (bit_rdy low) freezes the timer so a stalled stream never expires.
    assign w_tmr_en  = (r_state == SHIFT) & ~w_acc & w_bit_rdy;
    assign w_tmr_clr = (r_state != SHIFT) | w_acc;

    ser2par_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_word      <= '0;
            r_word_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_timeout | w_perr;

            if (w_last || w_timeout) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end else if (w_acc) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_shift_en) begin
                    r_sr <= w_sr_shift;
                end
            end

            if (w_load) begin
                r_word     <= w_word_nxt;
                r_word_vld <= 1'b1;
            end else if (bus.word_rdy) begin
                r_word_vld <= 1'b0;
            end
        end
    end

    assign bus.bit_rdy   = w_bit_rdy;
    assign bus.word_out  = r_word;
    assign bus.word_vld  = r_word_vld;
    assign bus.frame_err = r_frame_err;
    assign bus.bit_cnt   = r_cnt;

endmodule
`default_nettype wire
